// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants; also imported by the downstream bit
// generator for the visible-area bounds.
package vga_pkg;
   localparam int CNT_W = 10;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;

   localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
   localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;
   localparam int H_START = DEF_H_SYNC + DEF_H_BACK;
   localparam int V_START = DEF_V_SYNC + DEF_V_BACK;
   localparam int H_END   = H_START + DEF_H_ACTIVE;
   localparam int V_END   = V_START + DEF_V_ACTIVE;

   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/vga_timing_controller_if.sv
// Raster timing bundle from the timing controller to the monitor pins and
// the bit generator.
interface vga_timing_controller_if;
   import vga_pkg::*;

   logic hsync;
   logic vsync;
   cnt_t hcount;
   cnt_t vcount;
   logic display_pixel;
   logic pixel_tick;
   logic frame_start;

   modport master (
      output hsync, vsync, hcount, vcount, display_pixel, pixel_tick, frame_start
   );
   modport slave (
      input hsync, vsync, hcount, vcount, display_pixel, pixel_tick, frame_start
   );
endinterface

// File: rtl/vga_pixel_tick.sv
// Divides the system clock down to the pixel rate. adv is the internal
// advance enable; pixel_tick is its registered copy, aligned with the counters.
module vga_pixel_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic adv,
   output logic pixel_tick
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          tick_q, tick_d;

   always_comb begin
      adv    = (div_q == DIV_MAX);
      div_d  = adv ? '0 : div_q + 1'b1;
      tick_d = adv;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign pixel_tick = tick_q;
endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster counters and sync/enable decodes. Decodes come from the
// next-state counts so every registered output lines up in the same clk.
module vga_timing_controller
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   vga_timing_controller_if.master vga
);
   localparam int HT   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int VT   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int H_LO = H_SYNC + H_BACK;
   localparam int V_LO = V_SYNC + V_BACK;
   localparam int H_HI = H_LO + H_ACTIVE;
   localparam int V_HI = V_LO + V_ACTIVE;
   localparam cnt_t H_LAST = cnt_t'(HT - 1);
   localparam cnt_t V_LAST = cnt_t'(VT - 1);

   generate
      if (CLK_DIV < 1) begin : g_bad_div
         $error("CLK_DIV must be at least 1");
      end
      if (HT > 1024) begin : g_bad_ht
         $error("horizontal total exceeds 10-bit counter range");
      end
      if (VT > 1024) begin : g_bad_vt
         $error("vertical total exceeds 10-bit counter range");
      end
   endgenerate

   logic adv, pixel_tick_w;
   logic h_wrap, v_wrap;
   cnt_t hcount_q, hcount_d;
   cnt_t vcount_q, vcount_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic display_q, display_d;
   logic frame_start_q, frame_start_d;

   vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv        (adv),
      .pixel_tick (pixel_tick_w)
   );

   always_comb begin
      h_wrap   = (hcount_q == H_LAST);
      v_wrap   = (vcount_q == V_LAST);
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (adv) begin
         hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
         if (h_wrap) vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end
      // int casts keep the bound compares correct even when a bound hits 1024
      hsync_d       = int'(hcount_d) >= H_SYNC;
      vsync_d       = int'(vcount_d) >= V_SYNC;
      display_d     = (int'(hcount_d) >= H_LO) && (int'(hcount_d) < H_HI) &&
                      (int'(vcount_d) >= V_LO) && (int'(vcount_d) < V_HI);
      frame_start_d = adv && h_wrap && v_wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         display_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_q     <= display_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.hcount        = hcount_q;
   assign vga.vcount        = vcount_q;
   assign vga.hsync         = hsync_q;
   assign vga.vsync         = vsync_q;
   assign vga.display_pixel = display_q;
   assign vga.frame_start   = frame_start_q;
   assign vga.pixel_tick    = pixel_tick_w;
endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench: default geometry (A), CLK_DIV=1 (B) and a shrunken
// geometry (C) so full frames and wraps fit in a short run.
module tb_vga_timing_controller;
   import vga_pkg::*;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [9:0] h;
      logic [9:0] v;
      logic       de;
      logic       tk;
      logic       fs;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc;
   int   n_chk = 0;
   int   n_pass = 0;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   // edges seen since reset release; the model is a closed form of this
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   vga_timing_controller_if vif_a ();
   vga_timing_controller_if vif_b ();
   vga_timing_controller_if vif_c ();

   vga_timing_controller u_a (.clk(clk), .rst_n(rst_n), .vga(vif_a));

   vga_timing_controller #(.CLK_DIV(1)) u_b (.clk(clk), .rst_n(rst_n), .vga(vif_b));

   vga_timing_controller #(
      .CLK_DIV(2), .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1)
   ) u_c (.clk(clk), .rst_n(rst_n), .vga(vif_c));

   function automatic obs_t sample(int w);
      obs_t o;
      case (w)
         0: o = '{vif_a.hsync, vif_a.vsync, vif_a.hcount, vif_a.vcount,
                  vif_a.display_pixel, vif_a.pixel_tick, vif_a.frame_start};
         1: o = '{vif_b.hsync, vif_b.vsync, vif_b.hcount, vif_b.vcount,
                  vif_b.display_pixel, vif_b.pixel_tick, vif_b.frame_start};
         default: o = '{vif_c.hsync, vif_c.vsync, vif_c.hcount, vif_c.vcount,
                        vif_c.display_pixel, vif_c.pixel_tick, vif_c.frame_start};
      endcase
      return o;
   endfunction

   function automatic obs_t model(int n, int cd, int hs, int hb, int ha, int hf,
                                  int vs, int vb, int va, int vf);
      obs_t o;
      int ht = hs + hb + ha + hf;
      int vt = vs + vb + va + vf;
      int k  = n / cd;
      int h  = k % ht;
      int v  = (k / ht) % vt;
      o.h  = 10'(h);
      o.v  = 10'(v);
      o.hs = (h >= hs);
      o.vs = (v >= vs);
      o.de = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
      o.tk = (n >= 1) && ((n % cd) == 0);
      o.fs = o.tk && (k > 0) && ((k % (ht * vt)) == 0);
      return o;
   endfunction

   function automatic obs_t expect_for(int w, int n);
      case (w)
         0: return model(n, 2, 96, 48, 640, 16, 2, 33, 480, 10);
         1: return model(n, 1, 96, 48, 640, 16, 2, 33, 480, 10);
         default: return model(n, 2, 4, 3, 8, 2, 2, 2, 4, 1);
      endcase
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("h=%0d v=%0d hs=%b vs=%b de=%b tk=%b fs=%b",
                       o.h, o.v, o.hs, o.vs, o.de, o.tk, o.fs);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      obs_t e, o;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         e = expect_for(w, 0);
         o = sample(w);
         n_chk++;
         if (o !== e) $display("FAIL reset_dut%0d: got %s want %s", w, fmt(o), fmt(e));
         else n_pass++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(expect_for(0, cyc + 1));
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         o = sample(0);
         n_chk++;
         if (o !== e) $display("FAIL startup_c%0d: got %s want %s", cyc, fmt(o), fmt(e));
         else n_pass++;
         if (cyc == 1) begin
            n_chk++;
            if (o.tk !== 1'b0) $display("FAIL startup_tick1: got %b want 0", o.tk);
            else n_pass++;
         end
         if (cyc == 2) begin
            n_chk++;
            if (o.tk !== 1'b1 || o.h !== 10'd1)
               $display("FAIL startup_tick2: got tk=%b h=%0d want tk=1 h=1", o.tk, o.h);
            else n_pass++;
         end
      end
   endtask

   task automatic test_line();
      obs_t e, o;
      int lo = 0;
      int h_last = -1;
      do_reset();
      if (!sample(0).hs) lo++;
      for (int i = 0; i < 1600; i++) begin
         exp_q.push_back(expect_for(0, cyc + 1));
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         o = sample(0);
         n_chk++;
         if (o !== e) $display("FAIL line_c%0d: got %s want %s", cyc, fmt(o), fmt(e));
         else n_pass++;
         if (cyc < 1600 && !o.hs) lo++;
         if (cyc == 1599) h_last = int'(o.h);
      end
      n_chk++;
      if (lo != 192) $display("FAIL hsync_low_clks: got %0d want 192", lo);
      else n_pass++;
      n_chk++;
      if (h_last != H_TOTAL - 1) $display("FAIL h_before_wrap: got %0d want 799", h_last);
      else n_pass++;
      n_chk++;
      if (o.h !== 10'd0 || o.v !== 10'd1)
         $display("FAIL line_wrap: got h=%0d v=%0d want h=0 v=1", o.h, o.v);
      else n_pass++;
   endtask

   task automatic test_visible_window();
      obs_t e, o;
      int cnt34 = 0, cnt35 = 0;
      logic d143 = 1'bx, d144 = 1'bx, d783 = 1'bx, d784 = 1'bx;
      while (cyc < (V_START + 1) * H_TOTAL * 2) begin
         exp_q.push_back(expect_for(0, cyc + 1));
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         o = sample(0);
         n_chk++;
         if (o !== e) $display("FAIL window_c%0d: got %s want %s", cyc, fmt(o), fmt(e));
         else n_pass++;
         if (int'(e.v) == V_START - 1 && o.de) cnt34++;
         if (int'(e.v) == V_START) begin
            if (o.de) cnt35++;
            if (int'(e.h) == H_START - 1) d143 = o.de;
            if (int'(e.h) == H_START)     d144 = o.de;
            if (int'(e.h) == H_END - 1)   d783 = o.de;
            if (int'(e.h) == H_END)       d784 = o.de;
         end
      end
      n_chk++;
      if (cnt35 != DEF_H_ACTIVE * 2) $display("FAIL de_clks_line35: got %0d want 1280", cnt35);
      else n_pass++;
      n_chk++;
      if (cnt34 != 0) $display("FAIL de_clks_line34: got %0d want 0", cnt34);
      else n_pass++;
      n_chk++;
      if ({d143, d144, d783, d784} !== 4'b0110)
         $display("FAIL de_edges_143_144_783_784: got %b%b%b%b want 0110", d143, d144, d783, d784);
      else n_pass++;
   endtask

   task automatic test_clk_div1();
      obs_t e, o;
      int tk_lo = 0, wrap_at = -1;
      do_reset();
      for (int i = 0; i < 1700; i++) begin
         exp_q.push_back(expect_for(1, cyc + 1));
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         o = sample(1);
         n_chk++;
         if (o !== e) $display("FAIL div1_c%0d: got %s want %s", cyc, fmt(o), fmt(e));
         else n_pass++;
         if (!o.tk) tk_lo++;
         if (wrap_at < 0 && o.h == 10'd0 && o.tk) wrap_at = cyc;
      end
      n_chk++;
      if (tk_lo != 0) $display("FAIL div1_tick_low_clks: got %0d want 0", tk_lo);
      else n_pass++;
      n_chk++;
      if (wrap_at != 800) $display("FAIL div1_line_clks: got %0d want 800", wrap_at);
      else n_pass++;
   endtask

   task automatic test_frame_wrap();
      obs_t e, o;
      int fs_cnt = 0, fs1 = -1, fs2 = -1, vs_lo = 0, de_v4 = 0, de_v8 = 0;
      do_reset();
      for (int i = 0; i < 700; i++) begin
         exp_q.push_back(expect_for(2, cyc + 1));
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         o = sample(2);
         n_chk++;
         if (o !== e) $display("FAIL frame_c%0d: got %s want %s", cyc, fmt(o), fmt(e));
         else n_pass++;
         if (o.fs) begin
            fs_cnt++;
            if (fs1 < 0) fs1 = cyc; else if (fs2 < 0) fs2 = cyc;
            n_chk++;
            if (o.h !== 10'd0 || o.v !== 10'd0)
               $display("FAIL frame_start_pos: got h=%0d v=%0d want 0 0", o.h, o.v);
            else n_pass++;
         end
         if (cyc >= 306 && cyc < 612) begin
            if (!o.vs) vs_lo++;
            if (e.v == 10'd4 && o.de) de_v4++;
            if (e.v == 10'd8 && o.de) de_v8++;
         end
      end
      n_chk++;
      if (fs_cnt != 2) $display("FAIL frame_start_count: got %0d want 2", fs_cnt);
      else n_pass++;
      n_chk++;
      if (fs1 != 306 || fs2 - fs1 != 306)
         $display("FAIL frame_period: got first=%0d period=%0d want 306 306", fs1, fs2 - fs1);
      else n_pass++;
      n_chk++;
      if (vs_lo != 68) $display("FAIL vsync_low_clks: got %0d want 68", vs_lo);
      else n_pass++;
      n_chk++;
      if (de_v4 != 16 || de_v8 != 0)
         $display("FAIL de_top_bottom_rows: got %0d/%0d want 16/0", de_v4, de_v8);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      obs_t e, o;
      int found = 0, fs_cnt = 0;
      do_reset();
      for (int i = 0; i < 400 && found == 0; i++) begin
         exp_q.push_back(expect_for(2, cyc + 1));
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         o = sample(2);
         n_chk++;
         if (o !== e) $display("FAIL midframe_c%0d: got %s want %s", cyc, fmt(o), fmt(e));
         else n_pass++;
         if (e.h == 10'd10 && e.v == 10'd5) found = 1;
      end
      n_chk++;
      if (found == 0) $display("FAIL reach_10_5: got not reached want reached");
      else n_pass++;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int w = 0; w < 3; w += 2) begin
         e = expect_for(w, 0);
         o = sample(w);
         n_chk++;
         if (o !== e) $display("FAIL async_reset_dut%0d: got %s want %s", w, fmt(o), fmt(e));
         else n_pass++;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         exp_q.push_back(expect_for(2, cyc + 1));
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         o = sample(2);
         n_chk++;
         if (o !== e) $display("FAIL post_reset_c%0d: got %s want %s", cyc, fmt(o), fmt(e));
         else n_pass++;
         if (o.fs) fs_cnt++;
      end
      n_chk++;
      if (fs_cnt != 0) $display("FAIL frame_start_on_release: got %0d want 0", fs_cnt);
      else n_pass++;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_line();
      test_visible_window();
      test_clk_div1();
      test_frame_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
